// File: rtl/alu_share_arb_pkg.sv
// Shared definitions for the two-port ALU arbiter: RV32 aluctr codes,
// FSM state encoding and the legal-opcode decode.
package alu_share_arb_pkg;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b1000;
    localparam logic [3:0] ALU_SLL  = 4'b0001;
    localparam logic [3:0] ALU_SLT  = 4'b0010;
    localparam logic [3:0] ALU_SLTU = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_SRA  = 4'b1101;
    localparam logic [3:0] ALU_OR   = 4'b0110;
    localparam logic [3:0] ALU_AND  = 4'b0111;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    function automatic logic aluctr_legal(input logic [3:0] ctr);
        case (ctr)
            ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
            ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND: return 1'b1;
            default:                                    return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_share_arb_if.sv
// One requester port of the ALU arbiter: request channel plus response channel.
// Handshake: a transfer happens on a clock edge where valid && ready; the sender
// holds valid and payload stable until that edge, and ready may depend on valid.
interface alu_share_arb_if #(
    parameter int XLEN = 32
) ();
    logic            req_valid;
    logic            req_ready;
    logic [3:0]      req_aluctr;
    logic [XLEN-1:0] req_a;
    logic [XLEN-1:0] req_b;

    logic            rsp_valid;
    logic            rsp_ready;
    logic [XLEN-1:0] rsp_result;
    logic            rsp_zero;
    logic            rsp_less;
    logic            rsp_err;

    modport master (
        output req_valid, req_aluctr, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_result, rsp_zero, rsp_less, rsp_err
    );

    modport slave (
        input  req_valid, req_aluctr, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_result, rsp_zero, rsp_less, rsp_err
    );
endinterface

// File: rtl/alu_share_arb_rr_arb2.sv
// Two-way round-robin grant: a lone requester wins, on a tie the port that
// did not win last time wins.
module rr_arb2 (
    input  logic [1:0] i_valid,
    input  logic       i_last,
    input  logic       i_en,
    output logic       o_grant,
    output logic       o_gnt_valid
);
    assign o_gnt_valid = i_en & (|i_valid);
    assign o_grant     = (i_valid == 2'b11) ? ~i_last : i_valid[1];
endmodule

// File: rtl/alu_share_arb.sv
// Shares one combinational RV32 ALU between the EX stage (port 0) and the
// address/branch unit (port 1); one operation in flight, IDLE -> EXEC -> RESP.
module alu_share_arb
    import alu_share_arb_pkg::*;
#(
    parameter int              XLEN       = 32,
    parameter logic [XLEN-1:0] ERR_RESULT = '0
) (
    input  logic            clk,
    input  logic            rstn,
    alu_share_arb_if.slave  if_p0,
    alu_share_arb_if.slave  if_p1,
    output logic [3:0]      o_alu_aluctr,
    output logic [XLEN-1:0] o_alu_a,
    output logic [XLEN-1:0] o_alu_b,
    input  logic [XLEN-1:0] i_alu_result,
    input  logic            i_alu_zero,
    input  logic            i_alu_less,
    output logic [1:0]      o_state
);
    logic [1:0]      r_state;
    logic            r_owner;
    logic            r_last;
    logic [3:0]      r_aluctr;
    logic [XLEN-1:0] r_a;
    logic [XLEN-1:0] r_b;
    logic [XLEN-1:0] r_result;
    logic            r_zero;
    logic            r_less;
    logic            r_err;

    logic [1:0]      w_valid;
    logic            w_grant;
    logic            w_accept;
    logic [3:0]      w_ctr;
    logic [XLEN-1:0] w_a;
    logic [XLEN-1:0] w_b;
    logic            w_rsp_ready;

    assign w_valid = {if_p1.req_valid, if_p0.req_valid};

    rr_arb2 u_arb (
        .i_valid     (w_valid),
        .i_last      (r_last),
        .i_en        (r_state == ST_IDLE),
        .o_grant     (w_grant),
        .o_gnt_valid (w_accept)
    );

    assign w_ctr = w_grant ? if_p1.req_aluctr : if_p0.req_aluctr;
    assign w_a   = w_grant ? if_p1.req_a      : if_p0.req_a;
    assign w_b   = w_grant ? if_p1.req_b      : if_p0.req_b;

    assign if_p0.req_ready = w_accept & ~w_grant;
    assign if_p1.req_ready = w_accept &  w_grant;

    // Only the owner's response ready matters; the idle port's ready is ignored.
    assign w_rsp_ready = r_owner ? if_p1.rsp_ready : if_p0.rsp_ready;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state  <= ST_IDLE;
            r_owner  <= 1'b0;
            r_last   <= 1'b1;
            r_aluctr <= 4'b0000;
            r_a      <= '0;
            r_b      <= '0;
            r_result <= '0;
            r_zero   <= 1'b0;
            r_less   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_owner <= w_grant;
                        r_last  <= w_grant;
                        // Illegal codes skip the ALU entirely, so alu_* keep their old values.
                        if (aluctr_legal(w_ctr)) begin
                            r_aluctr <= w_ctr;
                            r_a      <= w_a;
                            r_b      <= w_b;
                            r_state  <= ST_EXEC;
                        end else begin
                            r_result <= ERR_RESULT;
                            r_zero   <= 1'b0;
                            r_less   <= 1'b0;
                            r_err    <= 1'b1;
                            r_state  <= ST_RESP;
                        end
                    end
                end
                ST_EXEC: begin
                    r_result <= i_alu_result;
                    r_zero   <= i_alu_zero;
                    r_less   <= i_alu_less;
                    r_err    <= 1'b0;
                    r_state  <= ST_RESP;
                end
                ST_RESP: begin
                    if (w_rsp_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_alu_aluctr = r_aluctr;
    assign o_alu_a      = r_a;
    assign o_alu_b      = r_b;
    assign o_state      = r_state;

    assign if_p0.rsp_valid  = (r_state == ST_RESP) & ~r_owner;
    assign if_p1.rsp_valid  = (r_state == ST_RESP) &  r_owner;
    assign if_p0.rsp_result = r_result;
    assign if_p1.rsp_result = r_result;
    assign if_p0.rsp_zero   = r_zero;
    assign if_p1.rsp_zero   = r_zero;
    assign if_p0.rsp_less   = r_less;
    assign if_p1.rsp_less   = r_less;
    assign if_p0.rsp_err    = r_err;
    assign if_p1.rsp_err    = r_err;
endmodule

// File: tb/tb_alu_share_arb.sv
// Directed and randomized bench for alu_share_arb; the ALU itself and the
// expected results come from plain arithmetic on the operands.
module tb_alu_share_arb;
    import alu_share_arb_pkg::*;

    localparam int XLEN = 32;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    alu_share_arb_if #(.XLEN(XLEN)) p0_if ();
    alu_share_arb_if #(.XLEN(XLEN)) p1_if ();

    logic [3:0]      alu_aluctr;
    logic [XLEN-1:0] alu_a;
    logic [XLEN-1:0] alu_b;
    logic [XLEN-1:0] alu_result;
    logic            alu_zero;
    logic            alu_less;
    logic [1:0]      dut_state;

    alu_share_arb #(.XLEN(XLEN), .ERR_RESULT('0)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .if_p0        (p0_if),
        .if_p1        (p1_if),
        .o_alu_aluctr (alu_aluctr),
        .o_alu_a      (alu_a),
        .o_alu_b      (alu_b),
        .i_alu_result (alu_result),
        .i_alu_zero   (alu_zero),
        .i_alu_less   (alu_less),
        .o_state      (dut_state)
    );

    int errors = 0;
    int checks = 0;

    logic [3:0] legal_codes [10] = '{4'b0000, 4'b1000, 4'b0001, 4'b0010, 4'b0011,
                                     4'b0100, 4'b0101, 4'b1101, 4'b0110, 4'b0111};

    // Reference model state
    int              m_last;
    logic [3:0]      m_ctr;
    logic [XLEN-1:0] m_a;
    logic [XLEN-1:0] m_b;

    // Per-port request payloads used by run_txn
    logic [3:0]      pc [2];
    logic [XLEN-1:0] pa [2];
    logic [XLEN-1:0] pb [2];

    // Returns {less, zero, result}
    function automatic logic [XLEN+1:0] alu_fn(input logic [3:0] ctr,
                                               input logic [XLEN-1:0] a,
                                               input logic [XLEN-1:0] b);
        logic [XLEN-1:0] r;
        logic            lt;
        lt = $signed(a) < $signed(b);
        case (ctr)
            4'b0000: r = a + b;
            4'b1000: r = a - b;
            4'b0001: r = a << b[4:0];
            4'b0010: r = lt ? 32'd1 : 32'd0;
            4'b0011: begin lt = (a < b); r = lt ? 32'd1 : 32'd0; end
            4'b0100: r = a ^ b;
            4'b0101: r = a >> b[4:0];
            4'b1101: r = $unsigned($signed(a) >>> b[4:0]);
            4'b0110: r = a | b;
            4'b0111: r = a & b;
            default: r = 32'hDEADBEEF;
        endcase
        return {lt, (r == 32'd0), r};
    endfunction

    always_comb {alu_less, alu_zero, alu_result} = alu_fn(alu_aluctr, alu_a, alu_b);

    function automatic logic is_legal(input logic [3:0] ctr);
        foreach (legal_codes[i]) if (legal_codes[i] == ctr) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic get_ready(input int p);
        return (p == 1) ? p1_if.req_ready : p0_if.req_ready;
    endfunction
    function automatic logic get_rsp_valid(input int p);
        return (p == 1) ? p1_if.rsp_valid : p0_if.rsp_valid;
    endfunction
    function automatic logic [XLEN-1:0] get_result(input int p);
        return (p == 1) ? p1_if.rsp_result : p0_if.rsp_result;
    endfunction
    function automatic logic get_zero(input int p);
        return (p == 1) ? p1_if.rsp_zero : p0_if.rsp_zero;
    endfunction
    function automatic logic get_less(input int p);
        return (p == 1) ? p1_if.rsp_less : p0_if.rsp_less;
    endfunction
    function automatic logic get_err(input int p);
        return (p == 1) ? p1_if.rsp_err : p0_if.rsp_err;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_valid(input int p, input logic v);
        if (p == 1) p1_if.req_valid = v;
        else        p0_if.req_valid = v;
    endtask

    task automatic set_rsp_ready(input int p, input logic v);
        if (p == 1) p1_if.rsp_ready = v;
        else        p0_if.rsp_ready = v;
    endtask

    task automatic clear_inputs();
        p0_if.req_valid = 1'b0; p1_if.req_valid = 1'b0;
        p0_if.rsp_ready = 1'b0; p1_if.rsp_ready = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rstn = 1'b0;
        tick();
        tick();
        rstn = 1'b1;
        m_last = 1; m_ctr = 4'b0000; m_a = '0; m_b = '0;
    endtask

    task automatic check_idle_reset_state(input string tag);
        check({tag, "_state"},  {30'd0, dut_state}, {30'd0, ST_IDLE});
        check({tag, "_rdy0"},   p0_if.req_ready, 1'b0);
        check({tag, "_rdy1"},   p1_if.req_ready, 1'b0);
        check({tag, "_rspv0"},  p0_if.rsp_valid, 1'b0);
        check({tag, "_rspv1"},  p1_if.rsp_valid, 1'b0);
        check({tag, "_err0"},   p0_if.rsp_err, 1'b0);
        check({tag, "_err1"},   p1_if.rsp_err, 1'b0);
        check({tag, "_res"},    p0_if.rsp_result, 32'd0);
        check({tag, "_aluctr"}, {28'd0, alu_aluctr}, 32'd0);
        check({tag, "_alua"},   alu_a, 32'd0);
        check({tag, "_alub"},   alu_b, 32'd0);
    endtask

    // One transaction from request(s) on mask to response handshake; the loser
    // of a tie keeps requesting so no-accept outside IDLE is exercised.
    task automatic run_txn(input string tag, input logic [1:0] mask, input int hold);
        int              w;
        logic            legal;
        logic [XLEN+1:0] e;
        p0_if.req_aluctr = pc[0]; p0_if.req_a = pa[0]; p0_if.req_b = pb[0];
        p1_if.req_aluctr = pc[1]; p1_if.req_a = pa[1]; p1_if.req_b = pb[1];
        p0_if.req_valid = mask[0];
        p1_if.req_valid = mask[1];
        #1;
        w = (mask == 2'b11) ? (1 - m_last) : (mask[1] ? 1 : 0);
        check({tag, "_grant0"}, p0_if.req_ready, (w == 0));
        check({tag, "_grant1"}, p1_if.req_ready, (w == 1));
        tick();
        m_last = w;
        legal  = is_legal(pc[w]);
        e      = legal ? alu_fn(pc[w], pa[w], pb[w]) : {1'b0, 1'b0, 32'd0};
        set_valid(w, 1'b0);
        if (legal) begin
            m_ctr = pc[w]; m_a = pa[w]; m_b = pb[w];
            check({tag, "_exec_rspv"}, {p1_if.rsp_valid, p0_if.rsp_valid}, 2'b00);
            check({tag, "_exec_rdy"},  {p1_if.req_ready, p0_if.req_ready}, 2'b00);
            tick();
        end
        check({tag, "_aluctr"}, {28'd0, alu_aluctr}, {28'd0, m_ctr});
        check({tag, "_alua"},   alu_a, m_a);
        check({tag, "_alub"},   alu_b, m_b);
        check({tag, "_rspv"},   get_rsp_valid(w), 1'b1);
        check({tag, "_rspv_other"}, get_rsp_valid(1 - w), 1'b0);
        check({tag, "_result"}, get_result(w), e[XLEN-1:0]);
        check({tag, "_zero"},   get_zero(w), e[XLEN]);
        check({tag, "_less"},   get_less(w), e[XLEN+1]);
        check({tag, "_err"},    get_err(w), !legal);
        // The idle port's ready is asserted during the stall and must be ignored.
        set_rsp_ready(1 - w, 1'b1);
        for (int i = 0; i < hold; i++) begin
            tick();
            check({tag, "_hold_rspv"},   get_rsp_valid(w), 1'b1);
            check({tag, "_hold_result"}, get_result(w), e[XLEN-1:0]);
            check({tag, "_hold_other"},  get_rsp_valid(1 - w), 1'b0);
            check({tag, "_hold_rdy"},    {p1_if.req_ready, p0_if.req_ready}, 2'b00);
        end
        set_rsp_ready(w, 1'b1);
        tick();
        check({tag, "_done_rspv"}, get_rsp_valid(w), 1'b0);
        check({tag, "_done_state"}, {30'd0, dut_state}, {30'd0, ST_IDLE});
        check({tag, "_loser_rdy"}, get_ready(1 - w), mask[1 - w]);
        clear_inputs();
    endtask

    initial begin
        logic [1:0] mask;
        clear_inputs();
        p0_if.req_aluctr = '0; p0_if.req_a = '0; p0_if.req_b = '0;
        p1_if.req_aluctr = '0; p1_if.req_a = '0; p1_if.req_b = '0;
        pc[0] = '0; pa[0] = '0; pb[0] = '0;
        pc[1] = '0; pa[1] = '0; pb[1] = '0;

        // Reset values
        do_reset();
        check_idle_reset_state("reset");

        // Single request
        pc[0] = ALU_ADD; pa[0] = 32'd5; pb[0] = 32'd7;
        run_txn("single_add", 2'b01, 0);

        // Contention after reset: port 0, then port 1, then port 0 again
        do_reset();
        pc[0] = ALU_SUB;  pa[0] = 32'd3; pb[0] = 32'd3;
        pc[1] = ALU_SLTU; pa[1] = 32'd1; pb[1] = 32'd2;
        run_txn("tie1", 2'b11, 0);
        pc[0] = ALU_XOR;  pa[0] = 32'h0F0F_0F0F; pb[0] = 32'hFFFF_0000;
        run_txn("tie2", 2'b11, 0);
        run_txn("tie3", 2'b11, 0);

        // Back-pressure on port 1 with port 0 waiting
        pc[1] = ALU_OR; pa[1] = 32'h1200_0000; pb[1] = 32'h0000_0034;
        run_txn("bp_p1", 2'b11, 5);
        pc[0] = ALU_SLT; pa[0] = 32'hFFFF_FFFF; pb[0] = 32'd1;
        run_txn("bp_p0", 2'b01, 0);

        // Illegal opcode
        pc[0] = 4'b1111; pa[0] = 32'h1234; pb[0] = 32'h5678;
        run_txn("illegal", 2'b01, 2);

        // Reset while in EXEC
        p0_if.req_aluctr = ALU_AND; p0_if.req_a = 32'hFF; p0_if.req_b = 32'h0F;
        p0_if.req_valid = 1'b1;
        p0_if.rsp_ready = 1'b1;
        #1;
        tick();
        check("rst_exec_state_pre", {30'd0, dut_state}, {30'd0, ST_EXEC});
        p0_if.req_valid = 1'b0;
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        m_last = 1; m_ctr = 4'b0000; m_a = '0; m_b = '0;
        check_idle_reset_state("rst_exec");
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_exec_no_rsp", {p1_if.rsp_valid, p0_if.rsp_valid}, 2'b00);
        end
        clear_inputs();
        pc[0] = ALU_SLL; pa[0] = 32'd1; pb[0] = 32'd31;
        pc[1] = ALU_SRL; pa[1] = 32'h8000_0000; pb[1] = 32'd31;
        run_txn("rst_exec_tie", 2'b11, 0);

        // Arithmetic shift right
        pc[1] = ALU_SRA; pa[1] = 32'h8000_0000; pb[1] = 32'd4;
        run_txn("sra", 2'b10, 1);
        check("sra_const", alu_fn(ALU_SRA, 32'h8000_0000, 32'd4), {2'b10, 32'hF800_0000});

        // Randomized traffic
        for (int n = 0; n < 60; n++) begin
            for (int p = 0; p < 2; p++) begin
                pc[p] = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(0, 15))
                                                    : legal_codes[$urandom_range(0, 9)];
                pa[p] = $urandom;
                case ($urandom_range(0, 3))
                    0:       pb[p] = pa[p];
                    1:       pb[p] = 32'($urandom_range(0, 40));
                    default: pb[p] = $urandom;
                endcase
            end
            mask = 2'($urandom_range(1, 3));
            run_txn("rand", mask, $urandom_range(0, 3));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
